// File: rtl/leitor_registrador.sv
// Row-by-row scanner for the register bank: reads each row through a synchronous
// read port, streams it MSB-first over valid/ready and records all-ones rows.
// Optional PARITY_EN macro appends an even-parity bit after each row's data bits.
module leitor_registrador #(
   parameter int WIDTH = 8,
   parameter int ROWS  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      rd_en,
   output logic [$clog2(ROWS)-1:0]   rd_addr,
   input  logic [WIDTH-1:0]          rd_data,
   output logic                      sdata,
   output logic                      svalid,
   input  logic                      sready,
   output logic                      sof,
   output logic                      busy,
   output logic                      done,
   output logic [ROWS-1:0]           full_mask
);

   localparam int AW = $clog2(ROWS);
`ifdef PARITY_EN
   localparam int BITS = WIDTH + 1;
`else
   localparam int BITS = WIDTH;
`endif
   localparam int CW = $clog2(BITS);
   localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);
   localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      CAPT,
      SHIFT,
      FINISH
   } state_t;

   state_t           state;
   state_t           next;
   logic [AW-1:0]    row;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
`ifdef PARITY_EN
   logic             par;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         row       <= '0;
         cnt       <= '0;
         shreg     <= '0;
         full_mask <= '0;
`ifdef PARITY_EN
         par       <= 1'b0;
`endif
      end else begin
         state <= next;
         case (state)
            IDLE: begin
               if (start) begin
                  full_mask <= '0;
                  row       <= '0;
               end
            end
            CAPT: begin
               shreg          <= rd_data;
               full_mask[row] <= &rd_data;
               cnt            <= '0;
`ifdef PARITY_EN
               par            <= ^rd_data;
`endif
            end
            SHIFT: begin
               // Row advances together with the last accepted bit so ADDR sees the new row.
               if (sready) begin
                  shreg <= {shreg[WIDTH-2:0], 1'b0};
                  cnt   <= cnt + CW'(1);
                  if (cnt == LAST_BIT && row != LAST_ROW) begin
                     row <= row + AW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      next    = state;
      rd_en   = 1'b0;
      rd_addr = '0;
      sdata   = 1'b0;
      svalid  = 1'b0;
      sof     = 1'b0;
      done    = 1'b0;
      busy    = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               next = ADDR;
            end
         end
         ADDR: begin
            rd_en   = 1'b1;
            rd_addr = row;
            next    = CAPT;
         end
         CAPT: begin
            next = SHIFT;
         end
         SHIFT: begin
            svalid = 1'b1;
            sof    = (cnt == '0);
`ifdef PARITY_EN
            sdata  = (cnt == CW'(WIDTH)) ? par : shreg[WIDTH-1];
`else
            sdata  = shreg[WIDTH-1];
`endif
            if (sready && cnt == LAST_BIT) begin
               next = (row == LAST_ROW) ? FINISH : ADDR;
            end
         end
         FINISH: begin
            done = 1'b1;
            next = IDLE;
         end
         default: begin
            next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_leitor_registrador.sv
// Directed self-checking bench for leitor_registrador with a synchronous bank model.
// Honours PARITY_EN the same way as the design.
module tb_leitor_registrador;

   localparam int WIDTH = 8;
   localparam int ROWS  = 8;
`ifdef PARITY_EN
   localparam int BITS = WIDTH + 1;
`else
   localparam int BITS = WIDTH;
`endif

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             rd_en;
   logic [2:0]       rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic             sdata;
   logic             svalid;
   logic             sready;
   logic             sof;
   logic             busy;
   logic             done;
   logic [ROWS-1:0]  full_mask;

   logic [WIDTH-1:0] bank    [ROWS];
   logic [WIDTH-1:0] got_row [ROWS];
   logic             got_par [ROWS];

   int checks = 0;
   int errors = 0;
   int cyc;

   leitor_registrador #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .sdata     (sdata),
      .svalid    (svalid),
      .sready    (sready),
      .sof       (sof),
      .busy      (busy),
      .done      (done),
      .full_mask (full_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read bank: data appears one cycle after the strobe; noise while in reset.
   always @(posedge clk) begin
      if (!rst_n) begin
         rd_data <= WIDTH'($urandom);
      end else if (rd_en) begin
         rd_data <= bank[rd_addr];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one scan; mode 0 keeps sready high, mode 1 toggles it every cycle.
   task automatic applyStimulus(input int mode, input bit hold, output int cycles);
      int row;
      int bitidx;
      int nbits;
      bit prev_stall;
      logic prev_sdata;
      logic expbit;
      row = 0;
      bitidx = 0;
      nbits = 0;
      prev_stall = 1'b0;
      prev_sdata = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         got_row[r] = '0;
         got_par[r] = 1'b0;
      end
      sready = 1'b1;
      start  = 1'b1;
      tick();
      start  = hold;
      cycles = 1;
      while (!done && cycles < 400) begin
         if (prev_stall) begin
            checkOutput("hold_valid", svalid, 1);
            checkOutput("hold_data", sdata, prev_sdata);
         end
         if (rd_en) checkOutput("rd_addr", rd_addr, row);
         sready = (mode == 0) ? 1'b1 : cycles[0];
         if (svalid && sready && row < ROWS) begin
            expbit = (bitidx < WIDTH) ? bank[row][WIDTH-1-bitidx] : ^bank[row];
            checkOutput("sof", sof, (bitidx == 0));
            checkOutput("sdata", sdata, expbit);
            if (bitidx < WIDTH) got_row[row] = {got_row[row][WIDTH-2:0], sdata};
            else got_par[row] = sdata;
            nbits++;
            bitidx++;
            if (bitidx == BITS) begin
               bitidx = 0;
               row++;
            end
         end else if (svalid && sready) begin
            nbits++;
         end
         prev_stall = svalid && !sready;
         prev_sdata = sdata;
         tick();
         cycles++;
      end
      checkOutput("done_seen", done, 1);
      checkOutput("bit_count", nbits, ROWS * BITS);
      sready = 1'b1;
   endtask

   initial begin
      bank[0] = 8'hFF;
      bank[1] = 8'h81;
      bank[2] = 8'hA5;
      bank[3] = 8'h07;
      bank[4] = 8'h03;
      bank[5] = 8'h3C;
      bank[6] = 8'hFE;
      bank[7] = 8'h7F;

      // Reset with random inputs
      rst_n  = 1'b0;
      start  = 1'b0;
      sready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         start  = 1'($urandom);
         sready = 1'($urandom);
         tick();
         checkOutput("reset_outputs",
                     {rd_en, rd_addr, sdata, svalid, sof, busy, done, full_mask}, 0);
      end
      start  = 1'b0;
      sready = 1'b1;
      rst_n  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("idle_quiet", {busy, rd_en, svalid, done}, 0);
      end

      // Full scan, no backpressure
      applyStimulus(0, 1'b0, cyc);
      checkOutput("done_cycle", cyc, ROWS * (BITS + 2) + 1);
      checkOutput("full_mask", full_mask, 8'h01);
      checkOutput("row0", got_row[0], 8'hFF);
      checkOutput("row1", got_row[1], 8'h81);
      tick();
      checkOutput("done_pulse_end", {done, busy}, 0);
      checkOutput("mask_held", full_mask, 8'h01);

      // Backpressure
      applyStimulus(1, 1'b0, cyc);
      checkOutput("bp_row2", got_row[2], 8'hA5);
      checkOutput("bp_row7", got_row[7], 8'h7F);
      checkOutput("bp_mask", full_mask, 8'h01);
      tick();
      checkOutput("bp_idle", busy, 0);

      // start held across the whole scan
      applyStimulus(0, 1'b1, cyc);
      checkOutput("hold_done_cycle", cyc, ROWS * (BITS + 2) + 1);
      tick();
      checkOutput("hold_idle_gap", {busy, rd_en, done}, 0);
      tick();
      checkOutput("hold_restart", {busy, rd_en, rd_addr}, {1'b1, 1'b1, 3'd0});
      checkOutput("hold_restart_mask", full_mask, 8'h00);
      start = 1'b0;

      // Async reset in the middle of row 3
      cyc = 0;
      while (!(rd_en && rd_addr == 3'd3) && cyc < 200) begin
         tick();
         cyc++;
      end
      checkOutput("reach_row3", {rd_en, rd_addr}, {1'b1, 3'd3});
      tick();
      tick();
      tick();
      checkOutput("row3_shifting", svalid, 1);
      checkOutput("mask_partial", full_mask, 8'h01);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_outputs", {busy, svalid, done, rd_en, full_mask}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("abort_idle", {busy, svalid, done}, 0);
      applyStimulus(0, 1'b0, cyc);
      checkOutput("rescan_cycle", cyc, ROWS * (BITS + 2) + 1);
      checkOutput("rescan_mask", full_mask, 8'h01);
      checkOutput("rescan_row0", got_row[0], 8'hFF);

`ifdef PARITY_EN
      checkOutput("parity_row3", got_par[3], 1'b1);
      checkOutput("parity_row4", got_par[4], 1'b0);
      checkOutput("parity_row0", got_par[0], 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
